add4_arbiter: RTL and testbench

//  Shares one registered 4-operand adder (4 x DW-bit in, DW+2-bit sum) among NREQ requesters.
//  - Round-robin arbitration; one transaction in flight at a time.
//  - valid/ready handshakes on both sides.
//  - The result is returned with the winner's index.
//  - Sits between the sample producers and the summing datapath.

---
 rtl/add4_arb_pkg.sv | 31 +++
 rtl/add4_arbiter_sum4_pipe.sv | 33 +++
 rtl/add4_arbiter.sv | 125 ++++++++++++
 tb/tb_add4_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add4_arb_pkg.sv
// Shared definitions for the add4_arbiter slice: FSM state encoding and the
// round-robin pick helper.
package add4_arb_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE = S_IDLE,
      ST_BUSY = S_BUSY,
      ST_DONE = S_DONE
   } arb_state_e;

   // First set bit of valid at or after ptr, wrapping within nreq (<= 8) requesters.
   function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                          input logic [2:0] ptr,
                                          input int         nreq);
      logic [2:0] pick;
      int         idx;
      pick = '0;
      for (int i = 7; i >= 0; i--) begin
         if (i < nreq) begin
            idx = (int'(ptr) + i) % nreq;
            if (valid[3'(idx)]) pick = 3'(idx);
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/add4_arbiter_sum4_pipe.sv
// Registered 4-operand adder, ADD_LAT stages deep, with synchronous clear.
// The first stage captures the sum only on load; later stages shift freely.
module sum4_pipe #(
   parameter int DW      = 14,
   parameter int ADD_LAT = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic [4*DW-1:0] ops,
   output logic [DW+1:0]   sum
);

   logic [DW+1:0] stage [ADD_LAT];
   logic [DW+1:0] sum_comb;

   always_comb begin
      sum_comb = {2'b00, ops[0*DW +: DW]} + {2'b00, ops[1*DW +: DW]}
               + {2'b00, ops[2*DW +: DW]} + {2'b00, ops[3*DW +: DW]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ADD_LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= load ? sum_comb : '0;
         for (int i = 1; i < ADD_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign sum = stage[ADD_LAT-1];

endmodule

// File: rtl/add4_arbiter.sv
// Round-robin arbiter sharing one pipelined 4-operand adder among NREQ requesters.
// Optional per-requester grant counters when ADD4_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a request; req_ready offers the round-robin winner
// BUSY  | operands in the adder, lat_cnt counting down the pipeline
// DONE  | rsp_valid high, result held until the consumer accepts
module add4_arbiter
   import add4_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int DW      = 14,
   parameter int ADD_LAT = 1,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*4*DW-1:0] req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [DW+1:0]        rsp_sum,
   output logic                 busy
`ifdef ADD4_ARB_STATS_EN
   ,
   output logic [NREQ*16-1:0]   grant_cnt
`endif
);

   localparam int OPW = 4*DW;

   arb_state_e    state;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] winner;
   logic [IDW-1:0] id_q;
   logic [1:0]     lat_cnt;
   logic [7:0]     valid_ext;
   logic           grant;
   logic [OPW-1:0] win_ops;
   logic [DW+1:0]  pipe_sum;

   always_comb begin
      valid_ext = '0;
      valid_ext[NREQ-1:0] = req_valid;
   end

   assign winner  = IDW'(rr_pick(valid_ext, 3'(ptr), NREQ));
   assign grant   = (state == ST_IDLE) && (|req_valid);
   assign win_ops = OPW'(req_data >> (winner * OPW));

   always_comb begin
      req_ready = '0;
      if (grant) req_ready[winner] = 1'b1;
   end

   sum4_pipe #(.DW(DW), .ADD_LAT(ADD_LAT)) u_sum4_pipe (
      .clk  (clk),
      .rst  (rst),
      .load (grant),
      .ops  (win_ops),
      .sum  (pipe_sum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         id_q      <= '0;
         lat_cnt   <= '0;
         rsp_sum   <= '0;
         rsp_id    <= '0;
         rsp_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (grant) begin
                  id_q    <= winner;
                  ptr     <= (winner == IDW'(NREQ-1)) ? '0 : winner + 1'b1;
                  lat_cnt <= 2'(ADD_LAT-1);
                  busy    <= 1'b1;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (lat_cnt == 2'd0) begin
                  rsp_sum   <= pipe_sum;
                  rsp_id    <= id_q;
                  rsp_valid <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ADD4_ARB_STATS_EN
   // Saturating per-requester handshake counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && req_ready[i] && grant_cnt[i*16 +: 16] != 16'hFFFF)
               grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_add4_arbiter.sv
// Bench for add4_arbiter (NREQ=4, DW=14, ADD_LAT=1) against a transaction-level
// reference model; define ADD4_ARB_STATS_EN to also exercise the grant counters.
module tb_add4_arbiter;

   localparam int NREQ    = 4;
   localparam int DW      = 14;
   localparam int ADD_LAT = 1;
   localparam int OPW     = 4*DW;

   logic                 clk;
   logic                 rst;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ*OPW-1:0]  req_data;
   logic [NREQ-1:0]      req_ready;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_id;
   logic [DW+1:0]        rsp_sum;
   logic                 busy;
`ifdef ADD4_ARB_STATS_EN
   logic [NREQ*16-1:0]   grant_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // reference model: arbiter free / waiting on the adder / holding a result
   bit m_idle = 1'b1;
   bit m_hold = 1'b0;
   int m_wait = 0;
   int m_ptr  = 0;
   int m_sum  = 0;
   int m_id   = 0;
   int m_pend_sum = 0;
   int m_pend_id  = 0;
   int m_cnt [NREQ];

   add4_arbiter #(.NREQ(NREQ), .DW(DW), .ADD_LAT(ADD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .busy      (busy)
`ifdef ADD4_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (((v >> ((p + k) % NREQ)) & 4'b0001) != 4'b0000) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] exp_ready();
      int w;
      logic [NREQ-1:0] r;
      r = '0;
      if (m_idle) begin
         w = pick(req_valid, m_ptr);
         if (w >= 0) r = 4'b0001 << w;
      end
      return r;
   endfunction

   function automatic int op_sum(input int w);
      int s;
      s = 0;
      for (int k = 0; k < 4; k++) s += int'(DW'(req_data >> (w*OPW + k*DW)));
      return s;
   endfunction

   function automatic logic [NREQ*OPW-1:0] rep_data(input int val);
      logic [NREQ*OPW-1:0] d;
      d = '0;
      for (int k = 0; k < NREQ*4; k++) d[k*DW +: DW] = DW'(val);
      return d;
   endfunction

   function automatic logic [NREQ*OPW-1:0] rand_data();
      logic [NREQ*OPW-1:0] d;
      for (int k = 0; k < NREQ*4; k++)
         d[k*DW +: DW] = ($urandom_range(0, 7) == 0) ? {DW{1'b1}} : DW'($urandom);
      return d;
   endfunction

   // Moves the model across the clock edge that the current inputs are about to meet.
   task automatic advance();
      int w;
      if (rst) begin
         m_idle = 1'b1; m_hold = 1'b0; m_wait = 0; m_ptr = 0; m_sum = 0; m_id = 0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else if (m_idle) begin
         w = pick(req_valid, m_ptr);
         if (w >= 0) begin
            m_idle = 1'b0;
            m_wait = ADD_LAT;
            m_pend_sum = op_sum(w);
            m_pend_id  = w;
            m_ptr = (w + 1) % NREQ;
            if (m_cnt[w] < 65535) m_cnt[w]++;
         end
      end else if (m_wait > 0) begin
         m_wait--;
         if (m_wait == 0) begin
            m_hold = 1'b1; m_sum = m_pend_sum; m_id = m_pend_id;
         end
      end else if (m_hold && rsp_ready) begin
         m_hold = 1'b0;
         m_idle = 1'b1;
      end
   endtask

   task automatic apply(input logic r, input logic [NREQ-1:0] v,
                        input logic [NREQ*OPW-1:0] d, input logic rr);
      advance();
      @(negedge clk);
      rst = r; req_valid = v; req_data = d; rsp_ready = rr;
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < ADD_LAT + 3; i++) apply(1'b0, '0, '0, 1'b1);
   endtask

   task automatic test_reset();
      apply(1'b1, '0, '0, 1'b1);
      apply(1'b1, '0, '0, 1'b1);
      for (int c = 0; c < 4; c++) begin
         apply(1'b0, '0, '0, 1'b1);
         total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid c=%0d got=%b want=0", c, rsp_valid); end
         total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy c=%0d got=%b want=0", c, busy); end
         total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready c=%0d got=%b want=0000", c, req_ready); end
         total++; if (rsp_sum !== '0 || rsp_id !== '0) begin bad++; $display("FAIL reset_rsp_regs c=%0d sum=%0d id=%0d want=0/0", c, rsp_sum, rsp_id); end
      end
   endtask

   task automatic test_single();
      logic [NREQ*OPW-1:0] d;
      int seen, width;
      d = rep_data(1111);
      seen = -1; width = 0;
      apply(1'b0, 4'b0010, d, 1'b1);
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_grant got=%b want=0010", req_ready); end
      for (int c = 1; c <= 5; c++) begin
         apply(1'b0, '0, d, 1'b1);
         total++; if (rsp_valid !== m_hold) begin bad++; $display("FAIL single_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, m_hold); end
         if (rsp_valid) begin
            if (seen < 0) seen = c;
            width++;
            total++; if (rsp_sum !== 16'd4444 || rsp_id !== 2'd1) begin bad++; $display("FAIL single_result sum=%0d id=%0d want=4444/1", rsp_sum, rsp_id); end
         end
      end
      total++; if (seen != 2) begin bad++; $display("FAIL single_latency got=%0d want=2", seen); end
      total++; if (width != 1) begin bad++; $display("FAIL single_width got=%0d want=1", width); end
   endtask

   task automatic test_rotation();
      logic [NREQ*OPW-1:0] d;
      int g_idx [$];
      int g_cyc [$];
      int exp_order [5] = '{0, 1, 2, 3, 0};
      d = rep_data(3333);
      apply(1'b1, '0, '0, 1'b1);
      for (int c = 0; c < 16; c++) begin
         apply(1'b0, 4'hF, d, 1'b1);
         total++; if (req_ready !== exp_ready()) begin bad++; $display("FAIL rot_ready c=%0d got=%b want=%b", c, req_ready, exp_ready()); end
         for (int k = 0; k < NREQ; k++) if (req_ready[k]) begin g_idx.push_back(k); g_cyc.push_back(c); end
         if (rsp_valid) begin
            total++; if (rsp_sum !== 16'd13332) begin bad++; $display("FAIL rot_sum c=%0d got=%0d want=13332", c, rsp_sum); end
         end
      end
      total++;
      if (g_idx.size() < 5) begin
         bad++; $display("FAIL rot_count got=%0d want>=5", g_idx.size());
      end else begin
         for (int k = 0; k < 5; k++) if (g_idx[k] != exp_order[k]) begin
            bad++; $display("FAIL rot_order k=%0d got=%0d want=%0d", k, g_idx[k], exp_order[k]); break;
         end
         for (int k = 1; k < g_cyc.size(); k++) begin
            total++; if (g_cyc[k] - g_cyc[k-1] != ADD_LAT + 2) begin bad++; $display("FAIL rot_spacing k=%0d got=%0d want=%0d", k, g_cyc[k] - g_cyc[k-1], ADD_LAT + 2); end
         end
      end
      drain();
   endtask

   task automatic test_backpressure();
      logic [NREQ*OPW-1:0] d;
      int hold_cycles;
      logic [NREQ-1:0] last_ready;
      d = rep_data(16383);
      hold_cycles = 0;
      apply(1'b0, 4'b0100, d, 1'b0);
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_grant got=%b want=0100", req_ready); end
      last_ready = '0;
      for (int c = 1; c <= 8; c++) begin
         apply(1'b0, 4'b0001, d, (c >= 7) ? 1'b1 : 1'b0);
         total++; if (req_ready !== exp_ready()) begin bad++; $display("FAIL bp_ready c=%0d got=%b want=%b", c, req_ready, exp_ready()); end
         total++; if (rsp_valid !== m_hold) begin bad++; $display("FAIL bp_rsp_valid c=%0d got=%b want=%b", c, rsp_valid, m_hold); end
         if (m_hold) begin
            hold_cycles++;
            total++; if (rsp_sum !== 16'd65532 || rsp_id !== 2'd2) begin bad++; $display("FAIL bp_hold c=%0d sum=%0d id=%0d want=65532/2", c, rsp_sum, rsp_id); end
         end
         last_ready = req_ready;
      end
      total++; if (hold_cycles != 6) begin bad++; $display("FAIL bp_hold_len got=%0d want=6", hold_cycles); end
      total++; if (last_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant got=%b want=0001", last_ready); end
      drain();
   endtask

   task automatic test_reset_mid();
      logic [NREQ*OPW-1:0] d;
      d = rep_data(5555);
      apply(1'b0, 4'b0010, d, 1'b1);
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_grant got=%b want=0010", req_ready); end
      apply(1'b1, '0, d, 1'b1);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b want=1", busy); end
      for (int c = 0; c < 4; c++) begin
         apply(1'b0, '0, d, 1'b1);
         total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_discard c=%0d rsp_valid=%b busy=%b want=0/0", c, rsp_valid, busy); end
      end
      apply(1'b0, 4'b0110, d, 1'b1);
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL mid_lowest got=%b want=0010", req_ready); end
      drain();
   endtask

   task automatic test_random();
      logic [NREQ-1:0] exp_r;
      for (int c = 0; c < 400; c++) begin
         apply(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, NREQ'($urandom), rand_data(),
               ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         exp_r = exp_ready();
         total++; if (req_ready !== exp_r) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, req_ready, exp_r); end
         total++; if (rsp_valid !== m_hold || busy !== !m_idle) begin bad++; $display("FAIL rnd_state c=%0d rsp_valid=%b busy=%b want=%b/%b", c, rsp_valid, busy, m_hold, !m_idle); end
         if (m_hold) begin
            total++; if (int'(rsp_sum) != m_sum || int'(rsp_id) != m_id) begin bad++; $display("FAIL rnd_result c=%0d sum=%0d id=%0d want=%0d/%0d", c, rsp_sum, rsp_id, m_sum, m_id); end
         end
`ifdef ADD4_ARB_STATS_EN
         for (int k = 0; k < NREQ; k++) begin
            total++; if (int'(grant_cnt[k*16 +: 16]) != m_cnt[k]) begin bad++; $display("FAIL rnd_cnt c=%0d k=%0d got=%0d want=%0d", c, k, grant_cnt[k*16 +: 16], m_cnt[k]); end
         end
`endif
      end
      drain();
   endtask

`ifdef ADD4_ARB_STATS_EN
   task automatic test_stats();
      int exp_cnt [NREQ] = '{0, 0, 0, 3};
      apply(1'b1, '0, '0, 1'b1);
      for (int g = 0; g < 3; g++) begin
         apply(1'b0, 4'b1000, rep_data(g + 1), 1'b1);
         drain();
      end
      for (int k = 0; k < NREQ; k++) begin
         total++; if (int'(grant_cnt[k*16 +: 16]) != exp_cnt[k]) begin bad++; $display("FAIL stats_cnt k=%0d got=%0d want=%0d", k, grant_cnt[k*16 +: 16], exp_cnt[k]); end
      end
   endtask
`endif

   initial begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
      test_reset();
      test_single();
      test_rotation();
      test_backpressure();
      test_reset_mid();
      test_random();
`ifdef ADD4_ARB_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
